// File: rtl/qos_pkg.sv
// Shared widths and types for the four-buffer QoS packet store.
package qos_pkg;
  localparam int QOS_DEPTH = 6;
  localparam int QOS_CNT_W = 3;
  localparam int QOS_NBUF  = 4;
  localparam int QOS_PKT_W = 2;
  localparam int QOS_IDX_W = 2;

  typedef logic [QOS_PKT_W-1:0] pkt_t;
  typedef logic [QOS_IDX_W-1:0] buf_idx_t;
endpackage

// File: rtl/qos_buffer_bank_if.sv
// Enqueue / dequeue handshake and drop reporting between scheduler and buffer bank.
interface qos_buffer_bank_if;
  import qos_pkg::*;

  logic       in_valid;
  buf_idx_t   in_buf;
  pkt_t       in_data;
  logic       deq_req;
  logic       out_valid;
  pkt_t       out_data;
  buf_idx_t   out_buf;
  logic       drop;
  logic [7:0] drop_cnt;

  modport master (
    output in_valid, in_buf, in_data, deq_req,
    input  out_valid, out_data, out_buf, drop, drop_cnt
  );

  modport slave (
    input  in_valid, in_buf, in_data, deq_req,
    output out_valid, out_data, out_buf, drop, drop_cnt
  );
endinterface

// File: rtl/qos_queue6.sv
// One QoS buffer: two bit-planes plus occupancy; slot 0 is the oldest entry.
module qos_queue6
  import qos_pkg::*;
#(
  parameter int DEPTH = QOS_DEPTH,
  parameter int CNT_W = QOS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  pkt_t             wr_data,
  input  logic             rd_en,
  output pkt_t             head,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] plane0,
  output logic [DEPTH-1:0] plane1,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] plane0_nxt;
  logic [DEPTH-1:0] plane1_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] wr_idx;

  assign head  = {plane1[0], plane0[0]};
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A read shifts everything down first, so a simultaneous write lands one slot lower.
  always_comb begin
    plane0_nxt = rd_en ? (plane0 >> 1) : plane0;
    plane1_nxt = rd_en ? (plane1 >> 1) : plane1;
    wr_idx     = rd_en ? (count - CNT_W'(1)) : count;
    count_nxt  = count;
    if (wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CNT_W'(k) == wr_idx) begin
          plane0_nxt[k] = wr_data[0];
          plane1_nxt[k] = wr_data[1];
        end
      end
    end
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plane0 <= '0;
      plane1 <= '0;
      count  <= '0;
    end else begin
      plane0 <= plane0_nxt;
      plane1 <= plane1_nxt;
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/qos_buffer_bank.sv
// Four strict-priority QoS buffers with drop accounting; exposes bit-planes for the display path.
module qos_buffer_bank
  import qos_pkg::*;
#(
  parameter int DEPTH = QOS_DEPTH,
  parameter int CNT_W = QOS_CNT_W
) (
  input  logic               F25MHZ,
  input  logic               rst,
  qos_buffer_bank_if.slave   bus,
  output logic [DEPTH-1:0]   bf1_0,
  output logic [DEPTH-1:0]   bf1_1,
  output logic [DEPTH-1:0]   bf2_0,
  output logic [DEPTH-1:0]   bf2_1,
  output logic [DEPTH-1:0]   bf3_0,
  output logic [DEPTH-1:0]   bf3_1,
  output logic [DEPTH-1:0]   bf4_0,
  output logic [DEPTH-1:0]   bf4_1,
  output logic [CNT_W-1:0]   bf1_counter,
  output logic [CNT_W-1:0]   bf2_counter,
  output logic [CNT_W-1:0]   bf3_counter,
  output logic [CNT_W-1:0]   bf4_counter
);

  logic [QOS_NBUF-1:0] wr_en;
  logic [QOS_NBUF-1:0] rd_en;
  logic [QOS_NBUF-1:0] full;
  logic [QOS_NBUF-1:0] empty;
  pkt_t                head   [QOS_NBUF];
  logic [DEPTH-1:0]    plane0 [QOS_NBUF];
  logic [DEPTH-1:0]    plane1 [QOS_NBUF];
  logic [CNT_W-1:0]    count  [QOS_NBUF];

  logic     deq_hit;
  buf_idx_t deq_sel;
  logic     drop_nxt;

  logic       out_vld_p1;
  pkt_t       out_data_p1;
  buf_idx_t   out_buf_p1;
  logic       drop_p1;
  logic [7:0] drop_cnt_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  for (genvar g = 0; g < QOS_NBUF; g++) begin : g_q
    qos_queue6 #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_q (
      .clk     (F25MHZ),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_data (bus.in_data),
      .rd_en   (rd_en[g]),
      .head    (head[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .plane0  (plane0[g]),
      .plane1  (plane1[g]),
      .count   (count[g])
    );
  end

  // Priority is judged on pre-edge occupancy, so a same-cycle arrival never makes a buffer eligible.
  always_comb begin
    rd_en    = '0;
    wr_en    = '0;
    deq_hit  = 1'b0;
    deq_sel  = '0;
    drop_nxt = 1'b0;
    for (int i = 0; i < QOS_NBUF; i++) begin
      if (bus.deq_req && !deq_hit && !empty[i]) begin
        rd_en[i] = 1'b1;
        deq_sel  = buf_idx_t'(i);
        deq_hit  = 1'b1;
      end
    end
    for (int i = 0; i < QOS_NBUF; i++) begin
      if (bus.in_valid && (bus.in_buf == buf_idx_t'(i))) begin
        if (!full[i] || rd_en[i]) wr_en[i] = 1'b1;
        else                      drop_nxt = 1'b1;
      end
    end
  end

  // Output stage: served packet and drop status register on the sampling edge.
  always_ff @(posedge F25MHZ or posedge rst) begin
    if (rst) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_buf_p1  <= '0;
      drop_p1     <= 1'b0;
      drop_cnt_p1 <= '0;
    end else begin
      out_vld_p1 <= deq_hit;
      if (deq_hit) begin
        out_data_p1 <= head[deq_sel];
        out_buf_p1  <= deq_sel;
      end
      drop_p1 <= drop_nxt;
      if (drop_nxt) drop_cnt_p1 <= sat_inc8(drop_cnt_p1);
    end
  end

  assign bus.out_valid = out_vld_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.out_buf   = out_buf_p1;
  assign bus.drop      = drop_p1;
  assign bus.drop_cnt  = drop_cnt_p1;

  assign bf1_0 = plane0[0];
  assign bf1_1 = plane1[0];
  assign bf2_0 = plane0[1];
  assign bf2_1 = plane1[1];
  assign bf3_0 = plane0[2];
  assign bf3_1 = plane1[2];
  assign bf4_0 = plane0[3];
  assign bf4_1 = plane1[3];

  assign bf1_counter = count[0];
  assign bf2_counter = count[1];
  assign bf3_counter = count[2];
  assign bf4_counter = count[3];

endmodule
